// File: rtl/song_seq_ctrl.sv
// Transport/tempo controller: divides clk into musical steps, walks the song index, gates the voices.
// Commands act on the next clk edge; outputs are decoded from registers. No backpressure, commands are one-shot.
module song_seq_ctrl #(
    parameter int IDX_W = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play,
    input  logic             pause,
    input  logic             stop,
    input  logic [DIV_W-1:0] tempo_div,
    input  logic [DIV_W-1:0] gate_div,
    input  logic [IDX_W-1:0] song_len,
    input  logic             loop_en,
    output logic [IDX_W-1:0] note_index,
    output logic             step_pulse,
    output logic             gate,
    output logic             playing,
    output logic             paused,
    output logic             song_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] beat_cnt;
    logic [DIV_W-1:0] beat_last;
    logic             step_end;

    // tempo_div of 0 behaves as 1, so the last beat of a step is index 0 either way.
    assign beat_last = (tempo_div == '0) ? '0 : tempo_div - DIV_W'(1);
    // >= rather than == so a tempo lowered mid-step ends the step instead of wrapping beat_cnt.
    assign step_end  = (beat_cnt >= beat_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            note_index <= '0;
            beat_cnt   <= '0;
        end else if (stop) begin
            state      <= IDLE;
            note_index <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (play) begin
                        state      <= PLAY;
                        note_index <= '0;
                        beat_cnt   <= '0;
                    end
                end
                PAUSE: begin
                    if (play) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        state <= PAUSE;
                    end else if (step_end) begin
                        beat_cnt <= '0;
                        if (note_index != song_len) begin
                            note_index <= note_index + IDX_W'(1);
                        end else if (loop_en) begin
                            note_index <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign playing    = (state == PLAY);
    assign paused     = (state == PAUSE);
    assign song_done  = (state == DONE);
    assign step_pulse = playing && (beat_cnt == '0);
    assign gate       = playing && (beat_cnt < gate_div);

endmodule
